// File: rtl/mem_mover_pkg.sv
// Shared encodings and default widths for the memory block mover.
package mem_mover_pkg;

  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_ADDR_WIDTH  = 32;
  localparam int DEF_COUNT_WIDTH = 15;
  localparam int MEM_INDEX_BITS  = 14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/mem_block_mover_if.sv
// Control, status and memory-port signals of the block mover.
// The slave modport is the mover itself; the master modport is its owner plus the memory.
interface mem_block_mover_if
  import mem_mover_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
);

  logic                   start;
  logic                   mode;
  logic [ADDR_WIDTH-1:0]  srcAddr;
  logic [ADDR_WIDTH-1:0]  dstAddr;
  logic [COUNT_WIDTH-1:0] wordCount;
  logic [DATA_WIDTH-1:0]  fillValue;
  logic [DATA_WIDTH-1:0]  memDataOut;
  logic [ADDR_WIDTH-1:0]  memAddress;
  logic                   memWriteEnable;
  logic [DATA_WIDTH-1:0]  memDataIn;
  logic                   busy;
  logic                   done;
  logic [DATA_WIDTH-1:0]  xorSum;

  modport slave (
    input  start, mode, srcAddr, dstAddr, wordCount, fillValue, memDataOut,
    output memAddress, memWriteEnable, memDataIn, busy, done, xorSum
  );

  modport master (
    output start, mode, srcAddr, dstAddr, wordCount, fillValue, memDataOut,
    input  memAddress, memWriteEnable, memDataIn, busy, done, xorSum
  );

endinterface

// File: rtl/mem_block_mover.sv
// Block copy/fill engine driving a single-port memory; copy takes 2N+1 cycles, fill N+1, N=0 one cycle.
// No backpressure: start is only honoured in IDLE and ignored (not queued) while busy.
module mem_block_mover
  import mem_mover_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  mem_block_mover_if.slave bus
);

  state_t                 r_state;
  logic                   r_mode;
  logic [ADDR_WIDTH-1:0]  r_src;
  logic [ADDR_WIDTH-1:0]  r_dst;
  logic [COUNT_WIDTH-1:0] r_remaining;
  logic [DATA_WIDTH-1:0]  r_fill;
  logic [DATA_WIDTH-1:0]  r_xor;
  logic [ADDR_WIDTH-1:0]  r_mem_addr;
  logic                   r_mem_we;
  logic [DATA_WIDTH-1:0]  r_mem_wdata;
  logic                   r_busy;
  logic                   r_done;

  logic [ADDR_WIDTH-1:0]  w_dst_next;
  logic                   w_last;

  assign w_dst_next = r_dst + ADDR_WIDTH'(1);
  assign w_last     = (r_remaining == COUNT_WIDTH'(1));

  // Memory-port outputs are registered one state ahead, so they are valid for the whole
  // state they belong to and the async reset clears them without waiting for an edge.
  // r_mem_wdata doubles as the copy data buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_mode      <= MODE_COPY;
      r_src       <= '0;
      r_dst       <= '0;
      r_remaining <= '0;
      r_fill      <= '0;
      r_xor       <= '0;
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_mode      <= bus.mode;
            r_src       <= bus.srcAddr;
            r_dst       <= bus.dstAddr;
            r_remaining <= bus.wordCount;
            r_fill      <= bus.fillValue;
            r_xor       <= '0;
            r_busy      <= 1'b1;
            if (bus.wordCount == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else if (bus.mode == MODE_FILL) begin
              r_state     <= WRITE;
              r_mem_addr  <= bus.dstAddr;
              r_mem_we    <= 1'b1;
              r_mem_wdata <= bus.fillValue;
            end else begin
              r_state    <= READ;
              r_mem_addr <= bus.srcAddr;
            end
          end
        end

        READ: begin
          r_src       <= r_src + ADDR_WIDTH'(1);
          r_state     <= WRITE;
          r_mem_addr  <= r_dst;
          r_mem_we    <= 1'b1;
          r_mem_wdata <= bus.memDataOut;
        end

        WRITE: begin
          r_xor       <= r_xor ^ r_mem_wdata;
          r_dst       <= w_dst_next;
          r_remaining <= r_remaining - COUNT_WIDTH'(1);
          if (w_last) begin
            r_state     <= DONE;
            r_done      <= 1'b1;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
          end else if (r_mode == MODE_FILL) begin
            r_mem_addr  <= w_dst_next;
            r_mem_wdata <= r_fill;
          end else begin
            // r_src was already advanced past the word just copied.
            r_state     <= READ;
            r_mem_addr  <= r_src;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
          end
        end

        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.memAddress     = r_mem_addr;
  assign bus.memWriteEnable = r_mem_we;
  assign bus.memDataIn      = r_mem_wdata;
  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.xorSum         = r_xor;

endmodule

// File: tb/tb_mem_block_mover.sv
// Bench for mem_block_mover: behavioural 16K-word memory, table of operations checked against a
// sequential golden memory, plus hand-written reset-abort and start-while-busy sequences.
module tb_mem_block_mover;
  import mem_mover_pkg::*;

  typedef struct {
    logic        mode;
    logic [31:0] src;
    logic [31:0] dst;
    logic [14:0] cnt;
    logic [31:0] fill;
    int          exp_lat;
    int          exp_wr;
    int          exp_gap;
    logic [31:0] exp_xor;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_block_mover_if bus ();

  mem_block_mover dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem  [0:16383];
  logic [31:0] gold [0:16383];
  logic        mem_clr;
  logic        pl_vld;
  logic [13:0] pl_addr;
  logic [31:0] pl_dat;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16384; i++) mem[i] <= '0;
    end else if (pl_vld) begin
      mem[pl_addr] <= pl_dat;
    end else if (bus.memWriteEnable) begin
      mem[bus.memAddress[13:0]] <= bus.memDataIn;
    end
  end

  assign bus.memDataOut = mem[bus.memAddress[13:0]];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [13:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_vld  = 1'b1;
    pl_addr = a;
    pl_dat  = d;
    @(posedge clk);
    #1 pl_vld = 1'b0;
    gold[a] = d;
  endtask

  task automatic issue(input vec_t v);
    @(negedge clk);
    bus.mode      = v.mode;
    bus.srcAddr   = v.src;
    bus.dstAddr   = v.dst;
    bus.wordCount = v.cnt;
    bus.fillValue = v.fill;
    bus.start     = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Applies one operation to the golden memory, word by word in ascending order.
  task automatic model(input vec_t v);
    logic [31:0] s, d;
    for (int i = 0; i < int'(v.cnt); i++) begin
      s = v.src + 32'(i);
      d = v.dst + 32'(i);
      gold[d[13:0]] = (v.mode == MODE_FILL) ? v.fill : gold[s[13:0]];
    end
  endtask

  task automatic check_mem(input string name, input vec_t v);
    logic [31:0] d;
    for (int i = 0; i < int'(v.cnt); i++) begin
      d = v.dst + 32'(i);
      chk(name, mem[d[13:0]], gold[d[13:0]]);
    end
  endtask

  // Cycle c is the state entered at the c-th edge counting the accepting edge as 1.
  task automatic run_op(input string name, input vec_t v);
    int lat, nwr, last_wr;
    logic gap_ok, busy_at_done;
    lat = -1; nwr = 0; last_wr = 0; gap_ok = 1'b1; busy_at_done = 1'b0;
    issue(v);
    for (int c = 1; c <= 200 && lat < 0; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      if (bus.memWriteEnable) begin
        if (nwr > 0 && (c - last_wr) != v.exp_gap) gap_ok = 1'b0;
        last_wr = c;
        nwr++;
      end
      if (bus.done) begin
        lat = c;
        busy_at_done = bus.busy;
      end
    end
    chk({name, "_latency"}, 32'(lat), 32'(v.exp_lat));
    chk({name, "_writes"}, 32'(nwr), 32'(v.exp_wr));
    if (v.cnt > 15'd1) chk({name, "_write_spacing"}, 32'(gap_ok), 32'd1);
    chk({name, "_busy_at_done"}, 32'(busy_at_done), 32'd1);
    chk({name, "_xor"}, bus.xorSum, v.exp_xor);
    @(posedge clk);
    #1;
    chk({name, "_idle_busy"}, 32'(bus.busy), 32'd0);
    chk({name, "_idle_done"}, 32'(bus.done), 32'd0);
    chk({name, "_xor_hold"}, bus.xorSum, v.exp_xor);
    model(v);
    check_mem({name, "_mem"}, v);
  endtask

  vec_t vecs[5];
  vec_t v;
  int   nwr;
  int   dones;

  initial begin
    bus.start = 1'b0; bus.mode = 1'b0; bus.srcAddr = '0; bus.dstAddr = '0;
    bus.wordCount = '0; bus.fillValue = '0;
    pl_vld = 1'b0; pl_addr = '0; pl_dat = '0; mem_clr = 1'b1;
    for (int i = 0; i < 16384; i++) gold[i] = '0;

    vecs[0] = '{MODE_COPY, 32'd0,   32'd100,   15'd4, 32'd0,         9, 4, 2, 32'd16};
    vecs[1] = '{MODE_FILL, 32'd0,   32'd200,   15'd3, 32'hDEADBEEF,  4, 3, 1, 32'hDEADBEEF};
    vecs[2] = '{MODE_COPY, 32'd0,   32'd250,   15'd0, 32'd0,         1, 0, 2, 32'd0};
    vecs[3] = '{MODE_FILL, 32'd0,   32'd16382, 15'd4, 32'd5,         5, 4, 1, 32'd0};
    vecs[4] = '{MODE_COPY, 32'd300, 32'd301,   15'd3, 32'd0,         7, 3, 2, 32'd7};

    repeat (2) @(posedge clk);
    #1 mem_clr = 1'b0;
    chk("rst_addr", bus.memAddress, 32'd0);
    chk("rst_we", 32'(bus.memWriteEnable), 32'd0);
    chk("rst_wdata", bus.memDataIn, 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_xor", bus.xorSum, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    preload(14'd0, 32'd11);
    preload(14'd1, 32'd22);
    preload(14'd2, 32'd33);
    preload(14'd3, 32'd44);
    preload(14'd300, 32'd7);
    preload(14'd301, 32'd8);
    preload(14'd302, 32'd9);
    preload(14'd303, 32'd10);

    for (int k = 0; k < 5; k++) run_op($sformatf("vec%0d", k), vecs[k]);
    chk("wrap_idx0", mem[0], 32'd5);
    chk("wrap_idx1", mem[1], 32'd5);

    // Reset asserted mid-cycle during the second write of a 4-word copy.
    v = '{MODE_COPY, 32'd0, 32'd400, 15'd4, 32'd0, 9, 4, 2, 32'd0};
    issue(v);
    nwr = 0;
    for (int c = 1; c <= 40 && nwr < 2; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      if (bus.memWriteEnable) nwr++;
    end
    chk("abort_reach_2nd_write", 32'(nwr), 32'd2);
    #2 reset = 1'b1;
    #1;
    chk("abort_we_async", 32'(bus.memWriteEnable), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_addr", bus.memAddress, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus.done) dones++;
    end
    chk("abort_no_done", 32'(dones), 32'd0);
    chk("abort_idle_busy", 32'(bus.busy), 32'd0);
    chk("abort_word0", mem[400], gold[0]);
    chk("abort_word1_untouched", mem[401], 32'd0);
    gold[400] = gold[0];

    // A second start while busy must be dropped.
    v = '{MODE_FILL, 32'd0, 32'd500, 15'd3, 32'd9, 4, 3, 1, 32'd9};
    issue(v);
    dones = (bus.done) ? 1 : 0;
    @(negedge clk);
    bus.dstAddr   = 32'd600;
    bus.fillValue = 32'd77;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (bus.done) dones++;
    end
    chk("busy_start_one_done", 32'(dones), 32'd1);
    chk("busy_start_xor", bus.xorSum, 32'd9);
    chk("busy_start_no_dst600", mem[600], 32'd0);
    model(v);
    check_mem("busy_start_mem", v);

    v = '{MODE_FILL, 32'd0, 32'd700, 15'd1, 32'd3, 2, 1, 1, 32'd3};
    run_op("restart", v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_block_mover.md
Name: mem_block_mover

Overview:
Initiator-side engine for the single-port 32-bit data memory: it drives the memory's address, write-enable and write-data pins and consumes its combinational read data.
Performs either a block copy (read src word, then write it to dst) or a block fill (write one constant to N words).
Sits beside the CPU datapath, sharing the memory port through an external mux.
The owner selects the port while busy=1.
Provides start/busy/done status and a running XOR checksum of every word written.

Parameters:
DATA_WIDTH, 32, memory word width
ADDR_WIDTH, 32, memory address bus width; the memory uses only the low 14 bits as the word index
COUNT_WIDTH, 15, width of word count; covers up to 16384 words

Ports:
clk  input  1  system clock; all state changes on the rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
mode  input  1  0 = copy, 1 = fill
srcAddr  input  ADDR_WIDTH  first source word address (copy only)
dstAddr  input  ADDR_WIDTH  first destination word address
wordCount  input  COUNT_WIDTH  number of words to transfer
fillValue  input  DATA_WIDTH  constant written in fill mode
memDataOut  input  DATA_WIDTH  combinational read data from the memory at memAddress
memAddress  output  ADDR_WIDTH  memory address
memWriteEnable  output  1  memory write strobe, one cycle per written word
memDataIn  output  DATA_WIDTH  memory write data
busy  output  1  high from the cycle after start is accepted until the DONE cycle ends
done  output  1  one-cycle completion pulse
xorSum  output  DATA_WIDTH  XOR of all words written by the last/current operation

Behaviour:
- Reset values: all outputs 0, state IDLE, internal registers 0. Reset is asynchronous, so it is effective mid-operation.
- Reset mid-operation: memWriteEnable drops immediately without waiting for a clock edge. The partial transfer is abandoned and no done pulse is produced.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - start=1 at an edge latches srcAddr, dstAddr, wordCount, mode and fillValue into working registers and clears xorSum.
  - Next state: DONE if wordCount=0; else WRITE if mode=1; else READ.
  - start=0 stays in IDLE.
  - Inputs other than start are ignored outside the accepting edge.
- READ (copy only):
  - memAddress=src, memWriteEnable=0.
  - At the edge, memDataOut is captured into the data buffer and src is incremented by 1.
  - Next state: WRITE.
- WRITE:
  - memAddress=dst, memWriteEnable=1.
  - memDataIn = buffer in copy mode, fillValue register in fill mode.
  - At the edge: xorSum ^= written word, dst is incremented by 1, remaining count is decremented.
  - If remaining was 1: next state DONE.
  - Otherwise: READ in copy mode, WRITE in fill mode.
- DONE: done=1 and busy=1 for exactly this cycle; next state IDLE. The earliest restart is start sampled in the following IDLE cycle.
- Outputs outside READ/WRITE: memAddress=0, memWriteEnable=0, memDataIn=0.
- busy=1 in READ, WRITE and DONE.
- start while busy is ignored, not queued.
- Latency from the accepting edge to done high:
  - copy: 2N+1 cycles
  - fill: N+1 cycles
  - N=0: 1 cycle
- Address arithmetic: the 32-bit addresses wrap modulo 2^32. The memory's 14-bit index therefore wraps 16383 -> 0 naturally; no error is raised.
- Overlap: copy is always ascending. If dst is in (src, src+N), the already-overwritten source words are re-read; this is the defined behaviour.
- xorSum holds its final value after done until the next accepted start.

Decomposition:
- Shared package mem_mover_pkg:
  - state encoding constants (IDLE=2'd0, READ=2'd1, WRITE=2'd2, DONE=2'd3)
  - mode constants (MODE_COPY=1'b0, MODE_FILL=1'b1)
  - DATA_WIDTH/ADDR_WIDTH defaults
- Single module: FSM, two address counters, count register, data buffer, xorSum. No sub-module is warranted.

Test Plan:
- Copy, memory preloaded mem[0..3]=11,22,33,44; start with mode=0, src=0, dst=100, count=4.
  - memWriteEnable pulses 4 times, every other cycle.
  - Afterwards mem[100..103]=11,22,33,44.
  - done rises exactly 9 cycles after the accepting edge.
  - xorSum=11^22^33^44.
- Fill: mode=1, dst=200, count=3, fillValue=32'hDEADBEEF.
  - 3 consecutive write cycles; mem[200..202]=DEADBEEF.
  - done 4 cycles after start; xorSum=DEADBEEF.
- count=0 -> no memWriteEnable; done and busy high for one cycle, 1 cycle after start; xorSum=0.
- Wrap: fill with dst=16382, count=4, fillValue=5 -> writes land on memory indices 16382, 16383, 0, 1 (addresses 16382..16385).
- Reset during the second WRITE of a 4-word copy -> memWriteEnable drops asynchronously; only the first word is written; no done pulse; busy=0.
- start pulsed again while busy → ignored; exactly one done; the following start is accepted normally.
